ibwt: RTL
=========

# ibwt

Inverse Burrows-Wheeler Transform engine: the decoder counterpart of the `bwt` block. Accepts a BWT output column (L) one character per clock through the same en/adr/in_string/length load interface, plus the primary index. Recovers the original string with the LF-mapping walk and raises `done_flag`; the original string is then read back by address. Sits directly downstream of `bwt` in the compression datapath, or standalone for decode-only builds.

## Interface
- `ADDR_W`, 10: address/length width; max string length is 2^ADDR_W-1.
- `CHAR_W`, 8: symbol width; the count table has 2^CHAR_W entries.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  load enable; high = load phase, low after loading starts decode.
- `adr`  in  ADDR_W  write address during load, read address in DONE.
- `in_string`  in  CHAR_W  L-column character written at `adr`.
- `length`  in  ADDR_W  string length; sampled on the edge that sees `en` low in LOAD.
- `primary_idx`  in  ADDR_W  row of the original string in the sorted rotation matrix; sampled with `length`.
- `outstring`  out  CHAR_W  decoded character at `adr`; combinational when `done_flag`=1, else 0.
- `done_flag`  out  1  decode complete, output memory valid.
- `err`  out  1  present only with `IBWT_ERR_EN`.

## Operation
- States: IDLE, LOAD, COUNT, PREFIX, WALK, DONE.
- IDLE: `en`=1 → LOAD. The entry edge writes L[adr]=in_string and clears all count entries and `done_flag`.
- LOAD: every edge with `en`=1 writes L[adr]=in_string. Edge with `en`=0 captures `length` and `primary_idx`. Next state is COUNT, or DONE if `length`=0.
- COUNT: i = 0..length-1, one per cycle: rank[i]=cnt[L[i]]; cnt[L[i]]++.
- PREFIX: c = 0..255, one per cycle: C[c]=running sum; sum += cnt[c]. Sum is ADDR_W bits and never overflows, since length ≤ 2^ADDR_W-1.
- WALK: p←primary_idx, k←length-1. Each cycle: S[k]=L[p]; p←C[L[p]]+rank[p]; k--. Exit after the k=0 write.
- DONE: `done_flag`=1 and `outstring`=S[adr]. `en`=1 → LOAD, which clears `done_flag` on that edge and begins a new block.
- `en` changes during COUNT, PREFIX or WALK are ignored.
- Writes with `adr` ≥ `length` during LOAD are stored but never referenced.

## Timing
- Reset (async, any state): state=IDLE, `done_flag`=0, `outstring`=0, `err`=0, all count, C and rank entries = 0. L and S contents are don't-care.
- Let E0 be the edge sampling `en`=0 in LOAD. `done_flag` rises at edge E0 + 2·length + 256.
- For `length`=0, `done_flag` rises at E0+1.
- `outstring` has zero-cycle latency from `adr` in DONE.
- A reset mid-WALK aborts the block. A new LOAD is required and L is not retained as valid.

## Configuration
- `IBWT_ERR_EN` defined: adds the `err` port. If `length`=0 or `primary_idx` ≥ `length` at E0, the block sets `err`=1 and goes to DONE at E0+1; S reads as 0. `err` clears on LOAD entry.
- `IBWT_ERR_EN` undefined: no `err` port. `primary_idx` ≥ `length` gives unspecified S contents, but WALK still terminates after `length` cycles and `done_flag` timing is unchanged.

## Structure
- Package `ibwt_pkg`: state enum, `CHAR_W`, `ADDR_W`, `NSYM` = 2^CHAR_W.
- Sub-module `ibwt_count_table`: the NSYM×ADDR_W count/prefix register file. It provides async read, increment-on-index, prefix-sweep mode and a one-cycle clear.
- L, rank and S are ADDR_W-addressed arrays in the top level with asynchronous reads.

## Test plan
- Load L="nnbaaa", length=6, primary_idx=3 → `done_flag` at E0+268; reading adr 0..5 gives "banana".
- Load L="cab", length=3, primary_idx=0 → "abc"; `done_flag` at E0+262.
- Load L="a", length=1, primary_idx=0 → "a" at adr 0; `done_flag` at E0+258. Also length=0 → `done_flag` at E0+1.
- Decode "nnbaaa"/3, then assert `en` in DONE and load "cab"/0 → `done_flag` drops on the LOAD entry edge; second result is "abc" with no stale counts.
- Assert `rst_n`=0 mid-WALK → `done_flag`=0 and `outstring`=0 immediately; a full reload then decodes correctly.
- With `IBWT_ERR_EN`: length=4, primary_idx=5 → `err`=1 and `done_flag`=1 at E0+1, `outstring`=0.

Source files
------------

// File: rtl/ibwt_pkg.sv
// rtl/ibwt_pkg.sv - shared widths and FSM state encoding for the inverse BWT engine
package ibwt_pkg;
   localparam int ADDR_W = 10;
   localparam int CHAR_W = 8;
   localparam int NSYM   = 1 << CHAR_W;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COUNT,
      S_PREFIX,
      S_WALK,
      S_DONE
   } state_t;
endpackage

// File: rtl/ibwt_count_table.sv
// rtl/ibwt_count_table.sv - per-symbol count table, swept in place into prefix sums C[c]
module ibwt_count_table
   import ibwt_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   input  logic [CHAR_W-1:0] inc_idx,
   input  logic              prefix_en,
   input  logic [CHAR_W-1:0] prefix_idx,
   input  logic [CHAR_W-1:0] rd_idx,
   output logic [ADDR_W-1:0] rd_data
);
   logic [ADDR_W-1:0] tbl [NSYM];
   logic [ADDR_W-1:0] sum;

   // Counts become C[] in place: each sweep step stores the running sum, then adds the old count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSYM; i++) tbl[i] <= '0;
         sum <= '0;
      end else if (clr) begin
         for (int i = 0; i < NSYM; i++) tbl[i] <= '0;
         sum <= '0;
      end else if (inc) begin
         tbl[inc_idx] <= tbl[inc_idx] + ADDR_W'(1);
      end else if (prefix_en) begin
         tbl[prefix_idx] <= sum;
         sum             <= sum + tbl[prefix_idx];
      end
   end

   // Asynchronous read port.
   always_comb rd_data = tbl[rd_idx];
endmodule

// File: rtl/ibwt.sv
// rtl/ibwt.sv - inverse Burrows-Wheeler transform engine (optional err port: IBWT_ERR_EN)
module ibwt
   import ibwt_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [ADDR_W-1:0] adr,
   input  logic [CHAR_W-1:0] in_string,
   input  logic [ADDR_W-1:0] length,
   input  logic [ADDR_W-1:0] primary_idx,
   output logic [CHAR_W-1:0] outstring,
`ifdef IBWT_ERR_EN
   output logic              err,
`endif
   output logic              done_flag
);
   state_t            state, nstate;
   logic [ADDR_W-1:0] len_q, pidx_q, idx, p;
   logic [CHAR_W-1:0] l_mem [DEPTH];
   logic [CHAR_W-1:0] s_mem [DEPTH];
   logic [ADDR_W-1:0] rank  [DEPTH];
   logic [CHAR_W-1:0] l_cur, l_at_idx;
   logic [ADDR_W-1:0] tbl_rd;
   logic              load_entry, load_wr, bad_in;
`ifdef IBWT_ERR_EN
   logic              bad_q;
`endif

   assign load_entry = ((state == S_IDLE) || (state == S_DONE)) && en;
   assign load_wr    = load_entry || ((state == S_LOAD) && en);
   assign l_cur      = l_mem[p];
   assign l_at_idx   = l_mem[idx];
`ifdef IBWT_ERR_EN
   assign bad_in     = (length == '0) || (primary_idx >= length);
`else
   assign bad_in     = (length == '0);
`endif

   ibwt_count_table u_count_table (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (load_entry),
      .inc        (state == S_COUNT),
      .inc_idx    (l_at_idx),
      .prefix_en  (state == S_PREFIX),
      .prefix_idx (idx[CHAR_W-1:0]),
      .rd_idx     ((state == S_COUNT) ? l_at_idx : l_cur),
      .rd_data    (tbl_rd)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nstate;
   end

   // Next-state logic; en is only looked at in IDLE, LOAD and DONE.
   always_comb begin
      nstate = state;
      case (state)
         S_IDLE:   if (en) nstate = S_LOAD;
         S_LOAD:   if (!en) nstate = bad_in ? S_DONE : S_COUNT;
         S_COUNT:  if (idx == len_q - ADDR_W'(1)) nstate = S_PREFIX;
         S_PREFIX: if (idx == ADDR_W'(NSYM - 1)) nstate = S_WALK;
         S_WALK:   if (idx == '0) nstate = S_DONE;
         S_DONE:   if (en) nstate = S_LOAD;
         default:  nstate = S_IDLE;
      endcase
   end

   // Sequencing counters, captured block parameters and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q     <= '0;
         pidx_q    <= '0;
         idx       <= '0;
         p         <= '0;
         done_flag <= 1'b0;
`ifdef IBWT_ERR_EN
         bad_q     <= 1'b0;
         err       <= 1'b0;
`endif
      end else begin
         if (load_entry) begin
            done_flag <= 1'b0;
`ifdef IBWT_ERR_EN
            err       <= 1'b0;
`endif
         end
         case (state)
            S_LOAD: if (!en) begin
               len_q  <= length;
               pidx_q <= primary_idx;
               idx    <= '0;
`ifdef IBWT_ERR_EN
               bad_q  <= bad_in;
`endif
            end
            S_COUNT:  idx <= (idx == len_q - ADDR_W'(1)) ? '0 : idx + ADDR_W'(1);
            S_PREFIX: begin
               if (idx == ADDR_W'(NSYM - 1)) begin
                  idx <= len_q - ADDR_W'(1);
                  p   <= pidx_q;
               end else begin
                  idx <= idx + ADDR_W'(1);
               end
            end
            S_WALK: begin
               p   <= tbl_rd + rank[p];
               idx <= idx - ADDR_W'(1);
               if (idx == '0) done_flag <= 1'b1;
            end
            S_DONE: if (!en) begin
               done_flag <= 1'b1;
`ifdef IBWT_ERR_EN
               err       <= bad_q;
`endif
            end
            default: ;
         endcase
      end
   end

   // Rank of each L position among equal symbols before it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) rank[i] <= '0;
      end else if (state == S_COUNT) begin
         rank[idx] <= tbl_rd;
      end
   end

   // L column and recovered string storage; contents need no reset.
   always_ff @(posedge clk) begin
      if (load_wr) l_mem[adr] <= in_string;
      if (state == S_WALK) s_mem[idx] <= l_cur;
   end

   // Read-back port, forced to zero until a valid result exists.
`ifdef IBWT_ERR_EN
   always_comb outstring = (done_flag && !err) ? s_mem[adr] : '0;
`else
   always_comb outstring = done_flag ? s_mem[adr] : '0;
`endif
endmodule
